tt_sweep_ctrl: RTL and testbench
================================

Name: tt_sweep_ctrl

Overview:
Self-checking sequencer for the 4-input combinational SOP datapath (s = (~b&c) | (~a&b&~c) | (a&b&d)).
- On start, drives all 16 input vectors {a,b,c,d} onto the datapath in ascending order.
- After each vector, waits a settle interval, samples s and compares it against an expected truth table.
- Reports an observed truth table, a mismatch count and the first failing index.
- Sits between a test/config master and one instance of the combinational function; replaces hand-written exhaustive stimulus.

Parameters:
- SETTLE, 2, cycles each vector is held before s is sampled; legal range 1..15.
- N_IN, 4, number of function inputs. Fixed at 4; sizes vec_out and the 16-entry tables.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  sweep request; accepted only in IDLE.
- exp_tt  in  16  expected truth table; bit i = expected s for vector i. Captured when start is accepted.
- vec_out  out  4  drive to datapath; bit3=a, bit2=b, bit1=c, bit0=d.
- dut_s  in  1  datapath output s.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse; sweep complete.
- pass  out  1  err_cnt==0 at completion; held until the next accepted start.
- err_cnt  out  5  number of mismatching vectors, 0..16.
- first_fail  out  4  index of the lowest mismatching vector.
- first_fail_vld  out  1  at least one mismatch recorded.
- obs_tt  out  16  sampled s per vector; bit i = s for vector i.

Behaviour:
- Reset (async assert, sync release): state=IDLE; vec_out, busy, done, pass, err_cnt, first_fail, first_fail_vld, obs_tt, settle counter and captured expect register all 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - vec_out=0.
  - On start=1, capture exp_tt; clear err_cnt, obs_tt, first_fail, first_fail_vld and pass; set index=0; go to DRIVE.
- DRIVE:
  - vec_out=index for SETTLE cycles (settle counter counts 0..SETTLE-1), then go to SAMPLE.
- SAMPLE (1 cycle):
  - vec_out still = index.
  - Write obs_tt[index] = dut_s.
  - If dut_s != captured_exp[index]: err_cnt+1; if first_fail_vld=0, set first_fail=index and first_fail_vld=1.
  - If index==15, go to DONE; else index+1 and go to DRIVE.
- DONE (1 cycle):
  - done=1; pass=(err_cnt==0); busy=1 during this cycle; vec_out returns to 0 on exit; go to IDLE.
- Timing: each vector occupies SETTLE+1 cycles. With start accepted at edge 0, done is high in cycle 16*(SETTLE+1)+1, which is 49 for SETTLE=2.
- start is ignored in DRIVE, SAMPLE and DONE. It is not queued. exp_tt changes while busy have no effect.
- Index wrap: the 4-bit index is never incremented past 15; the sweep terminates instead.
- err_cnt saturates naturally at 16; 5 bits suffice.
- Results (obs_tt, err_cnt, first_fail*, pass) hold after done until the next accepted start.
- rst_n asserted mid-sweep: immediate return to reset values, no done pulse. The next start performs a full sweep from index 0.
- dut_s is sampled only in SAMPLE; its value in other states is don't-care.

Decomposition:
- Package tt_sweep_pkg holds:
  - state enum {IDLE, DRIVE, SAMPLE, DONE};
  - N_VEC=16;
  - EXP_TT_SOP=16'hAC3C, the golden table of the SOP function; ones at indices 2,3,4,5,10,11,13,15.
- One natural sub-module, tt_settle_timer: loadable down-counter with SETTLE terminal-count flag. Index, compare logic and FSM stay in tt_sweep_ctrl.

Test Plan:
- Golden: correct SOP function on vec_out/dut_s, exp_tt=16'hAC3C, SETTLE=2, pulse start → done in cycle 49, pass=1, err_cnt=0, obs_tt=16'hAC3C, first_fail_vld=0.
- Stuck-at-0: dut_s tied 0, exp_tt=16'hAC3C → err_cnt=8, first_fail=2, first_fail_vld=1, obs_tt=16'h0000, pass=0.
- Single fault: function output inverted only for vector 6 → err_cnt=1, first_fail=6, obs_tt=16'hAC7C, pass=0.
- Ignored start/expect: pulse start again at cycle 20 and change exp_tt to 16'h0000 at cycle 10 of a golden run → done still in cycle 49 only, pass=1, no second sweep.
- Reset mid-sweep: assert rst_n=0 while vec_out=7 → all outputs 0 immediately, no done; re-start → full 49-cycle sweep, golden results.
- Settle bound: SETTLE=1, golden function → done in cycle 33, pass=1; check dut_s is compared in the SAMPLE cycle for each of the 16 vectors.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep controller: FSM encodings,
// table size, the golden SOP truth table and a small error-count helper.
package tt_sweep_pkg;

  // Number of input vectors swept (2**4 for a 4-input function).
  localparam int N_VEC = 16;

  // Golden truth table of s = (~b&c) | (~a&b&~c) | (a&b&d), bit i = s({a,b,c,d}=i).
  localparam logic [15:0] EXP_TT_SOP = 16'hAC3C;

  // Sweep FSM encodings, kept as plain constants for older tool flows.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Error count after one compare; at most 16 mismatches so 5 bits never wrap.
  function automatic logic [4:0] next_err_cnt(input logic [4:0] cnt, input logic miss);
    return miss ? (cnt + 5'd1) : cnt;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that marks the last settle cycle of a driven vector.
// Loading sets the count to SETTLE-1; terminal count is reached at zero, so a
// vector is held for exactly SETTLE cycles before it is sampled.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE - 1);

  logic [3:0] cnt;

  // Reload at the start of each vector, then count down while enabled and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign tc = (cnt == 4'd0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sequencer: drives every input vector of a 4-input
// combinational function in ascending order, samples its output after a
// settle interval and compares against a captured expected table.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int N_IN   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_VEC-1:0]  exp_tt,
  output logic [N_IN-1:0]   vec_out,
  input  logic              dut_s,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        err_cnt,
  output logic [N_IN-1:0]   first_fail,
  output logic              first_fail_vld,
  output logic [N_VEC-1:0]  obs_tt
);

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  logic [1:0]       state;
  logic [N_IN-1:0]  index;
  logic [N_VEC-1:0] exp_q;
  logic             timer_load;
  logic             timer_en;
  logic             timer_tc;
  logic             mismatch;
  logic [4:0]       err_cnt_nxt;
  logic             start_ok;
  logic             last_vec;

  // Settle timer restarts for every new vector and only counts while driving.
  assign start_ok   = (state == ST_IDLE) && start;
  assign last_vec   = (index == LAST_IDX);
  assign timer_load = start_ok || ((state == ST_SAMPLE) && !last_vec);
  assign timer_en   = (state == ST_DRIVE);

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  // Compare of the sampled output against the expected bit for the current vector.
  assign mismatch    = (dut_s != exp_q[index]);
  assign err_cnt_nxt = next_err_cnt(err_cnt, mismatch);

  // Status outputs decode directly from the state so reset clears them at once.
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign vec_out = (state == ST_IDLE) ? '0 : index;

  // Sweep FSM: IDLE -> (DRIVE x SETTLE, SAMPLE) x 16 -> DONE -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      index <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            index <= '0;
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (timer_tc) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (last_vec) begin
            state <= ST_DONE;
          end else begin
            index <= index + 1'b1;
            state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Expected table is frozen at start so later changes on exp_tt cannot disturb a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
    end else if (start_ok) begin
      exp_q <= exp_tt;
    end
  end

  // Result registers: cleared on an accepted start, updated once per vector in SAMPLE, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= 5'd0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      obs_tt         <= '0;
      pass           <= 1'b0;
    end else if (start_ok) begin
      err_cnt        <= 5'd0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      obs_tt         <= '0;
      pass           <= 1'b0;
    end else if (state == ST_SAMPLE) begin
      obs_tt[index] <= dut_s;
      err_cnt       <= err_cnt_nxt;
      if (mismatch && !first_fail_vld) begin
        first_fail     <= index;
        first_fail_vld <= 1'b1;
      end
      if (last_vec) begin
        pass <= (err_cnt_nxt == 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: stimulus pushes the expected sweep
// result, per-instance monitors pop and compare whenever done is presented.
module tb_tt_sweep_ctrl;
  import tt_sweep_pkg::*;

  typedef struct {
    int         done_at;
    logic [4:0] err;
    logic [3:0] ff;
    logic       ffv;
    logic [15:0] obs;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] exp_a = '0, exp_b = '0;
  logic [3:0]  vec_a, vec_b;
  logic        s_a, s_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [4:0]  err_a, err_b;
  logic [3:0]  ff_a, ff_b;
  logic        ffv_a, ffv_b;
  logic [15:0] obs_a, obs_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   mode_a = 0;
  int   stable_a = 100, stable_b = 100;
  logic [3:0] last_a = '0, last_b = '0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  // Free-running count of rising edges, used to time the done pulse.
  always @(posedge clk) cyc = cyc + 1;

  tt_sweep_ctrl #(.SETTLE(2), .N_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .exp_tt(exp_a), .vec_out(vec_a),
    .dut_s(s_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_fail(ff_a), .first_fail_vld(ffv_a), .obs_tt(obs_a)
  );

  tt_sweep_ctrl #(.SETTLE(1), .N_IN(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .exp_tt(exp_b), .vec_out(vec_b),
    .dut_s(s_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_fail(ff_b), .first_fail_vld(ffv_b), .obs_tt(obs_b)
  );

  function automatic logic sop(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (~b & c) | (~a & b & ~c) | (a & b & d);
  endfunction

  // Slow datapath: output is wrong until the vector has been stable for 'settle' cycles.
  function automatic logic dp_model(input logic [3:0] v, input int stable, input int settle, input int mode);
    logic g;
    g = sop(v);
    if (stable < settle) g = ~g;
    case (mode)
      1:       return 1'b0;
      2:       return g ^ (v == 4'd6);
      default: return g;
    endcase
  endfunction

  assign s_a = dp_model(vec_a, stable_a, 2, mode_a);
  assign s_b = dp_model(vec_b, stable_b, 1, 0);

  // Track how many cycles each driven vector has been held.
  always @(negedge clk) begin
    if (vec_a != last_a) begin stable_a = 0; last_a = vec_a; end
    else if (stable_a < 100) stable_a = stable_a + 1;
    if (vec_b != last_b) begin stable_b = 0; last_b = vec_b; end
    else if (stable_b < 100) stable_b = stable_b + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Monitor for the SETTLE=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_a) begin
      if (q_a.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL a_unexpected_done: got done at edge %0d expected none", cyc);
      end else begin
        e = q_a.pop_front();
        check_output("a_done_cycle", cyc, e.done_at);
        check_output("a_busy_in_done", {31'd0, busy_a}, 32'd1);
        check_output("a_err_cnt", {27'd0, err_a}, {27'd0, e.err});
        check_output("a_first_fail", {28'd0, ff_a}, {28'd0, e.ff});
        check_output("a_first_fail_vld", {31'd0, ffv_a}, {31'd0, e.ffv});
        check_output("a_obs_tt", {16'd0, obs_a}, {16'd0, e.obs});
        check_output("a_pass", {31'd0, pass_a}, {31'd0, e.pass});
      end
    end
  end

  // Monitor for the SETTLE=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_b) begin
      if (q_b.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL b_unexpected_done: got done at edge %0d expected none", cyc);
      end else begin
        e = q_b.pop_front();
        check_output("b_done_cycle", cyc, e.done_at);
        check_output("b_err_cnt", {27'd0, err_b}, {27'd0, e.err});
        check_output("b_first_fail_vld", {31'd0, ffv_b}, {31'd0, e.ffv});
        check_output("b_obs_tt", {16'd0, obs_b}, {16'd0, e.obs});
        check_output("b_pass", {31'd0, pass_b}, {31'd0, e.pass});
      end
    end
  end

  // Issue a one-cycle start on the chosen instance and queue its expected result.
  task automatic apply_stimulus(input bit use_b, input logic [15:0] tbl, input exp_t e_in);
    exp_t e;
    e = e_in;
    @(negedge clk);
    e.done_at = cyc + 1 + 16 * ((use_b ? 1 : 2) + 1);
    if (use_b) begin start_b = 1'b1; exp_b = tbl; q_b.push_back(e); end
    else       begin start_a = 1'b1; exp_a = tbl; q_a.push_back(e); end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Bounded wait for every queued sweep to report.
  task automatic wait_sweeps();
    for (int i = 0; i < 300 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_checks++;
      $display("[TB] FAIL sweep_timeout: got %0d pending expected 0", q_a.size() + q_b.size());
      q_a.delete();
      q_b.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [4:0] err, input logic [3:0] ff, input logic ffv,
                              input logic [15:0] obs, input logic pass);
    exp_t e;
    e.done_at = 0; e.err = err; e.ff = ff; e.ffv = ffv; e.obs = obs; e.pass = pass;
    return e;
  endfunction

  initial begin
    bit hit7;
    $display("[TB] tt_sweep_ctrl scoreboard bench");
    #1;
    check_output("rst_vec_out", {28'd0, vec_a}, 32'd0);
    check_output("rst_busy", {31'd0, busy_a}, 32'd0);
    check_output("rst_done", {31'd0, done_a}, 32'd0);
    check_output("rst_pass", {31'd0, pass_a}, 32'd0);
    check_output("rst_err_cnt", {27'd0, err_a}, 32'd0);
    check_output("rst_obs_tt", {16'd0, obs_a}, 32'd0);
    check_output("rst_first_fail_vld", {31'd0, ffv_a}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Golden run, then results must hold after done.
    mode_a = 0;
    apply_stimulus(1'b0, EXP_TT_SOP, mk(5'd0, 4'd0, 1'b0, 16'hAC3C, 1'b1));
    wait_sweeps();
    check_output("hold_obs_tt", {16'd0, obs_a}, 32'h0000AC3C);
    check_output("hold_pass", {31'd0, pass_a}, 32'd1);
    check_output("idle_busy", {31'd0, busy_a}, 32'd0);

    // Stuck-at-0 output.
    mode_a = 1;
    apply_stimulus(1'b0, EXP_TT_SOP, mk(5'd8, 4'd2, 1'b1, 16'h0000, 1'b0));
    wait_sweeps();

    // Single fault at vector 6.
    mode_a = 2;
    apply_stimulus(1'b0, EXP_TT_SOP, mk(5'd1, 4'd6, 1'b1, 16'hAC7C, 1'b0));
    wait_sweeps();

    // Start and expected table changes while busy are ignored.
    mode_a = 0;
    begin
      exp_t e;
      e = mk(5'd0, 4'd0, 1'b0, 16'hAC3C, 1'b1);
      @(negedge clk);
      e.done_at = cyc + 1 + 48;
      start_a = 1'b1; exp_a = EXP_TT_SOP; q_a.push_back(e);
      for (int i = 1; i <= 25; i++) begin
        @(negedge clk);
        start_a = (i == 20);
        if (i == 10) exp_a = 16'h0000;
      end
      start_a = 1'b0;
    end
    wait_sweeps();
    repeat (60) @(negedge clk);
    check_output("no_second_sweep_busy", {31'd0, busy_a}, 32'd0);
    exp_a = EXP_TT_SOP;

    // Reset mid-sweep while vector 7 is driven.
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    hit7 = 1'b0;
    for (int i = 0; i < 100 && !hit7; i++) begin
      if (vec_a == 4'd7) hit7 = 1'b1;
      else @(negedge clk);
    end
    check_output("reach_vec7", {31'd0, hit7}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_vec_out", {28'd0, vec_a}, 32'd0);
    check_output("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    check_output("mid_rst_done", {31'd0, done_a}, 32'd0);
    check_output("mid_rst_err_obs", {11'd0, err_a, obs_a}, 32'd0);
    check_output("mid_rst_ff_pass", {26'd0, ff_a, ffv_a, pass_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(1'b0, EXP_TT_SOP, mk(5'd0, 4'd0, 1'b0, 16'hAC3C, 1'b1));
    wait_sweeps();

    // SETTLE=1 instance with a slow datapath: each vector is valid only in its SAMPLE cycle.
    apply_stimulus(1'b1, EXP_TT_SOP, mk(5'd0, 4'd0, 1'b0, 16'hAC3C, 1'b1));
    wait_sweeps();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
